counter_bank: RTL
=================

Name: counter_bank

Overview:
- Multi-channel, parametrised successor to the single up-counter.
- CHANNELS independent WIDTH-bit counters, each with:
  - up/down direction
  - programmable upper limit
  - wrap or saturate mode
  - synchronous load
  - terminal-count pulse
- Sits beside the existing counters as a general event/timer bank; all channels are clocked by clk and share one synchronous active-low reset.

Parameters:
- WIDTH, 8, counter width per channel in bits (>=2).
- CHANNELS, 4, number of independent channels (>=1).
- PRESCALE, 4, step divider ratio (>=1); used only when COUNTER_BANK_PRESCALE_EN is defined.

Ports:
- clk  input  1  system clock; all state updates on posedge clk.
- rst_n  input  1  reset, synchronous, active-low.
- cen  input  CHANNELS  per-channel count enable.
- dir  input  CHANNELS  per-channel direction: 1 = up, 0 = down.
- sat  input  CHANNELS  per-channel mode: 1 = saturate, 0 = wrap.
- wen  input  CHANNELS  per-channel load enable.
- dat  input  CHANNELS*WIDTH  load value; channel i at dat[i*WIDTH +: WIDTH].
- lim  input  CHANNELS*WIDTH  inclusive upper limit; channel i at lim[i*WIDTH +: WIDTH].
- o_cnt  output  CHANNELS*WIDTH  registered count values, same packing as dat.
- o_tc  output  CHANNELS  registered terminal-count pulse, per channel.

Behaviour:
- Reset: rst_n sampled low at posedge clk sets all o_cnt = 0, all o_tc = 0 and the prescaler = 0. Reset has priority over everything. Reset mid-count discards the count; no residual o_tc.
- Per-channel priority: reset > wen > counting step > hold.
- Load: wen[i]=1 sets o_cnt[i] to min(dat[i], lim[i]) at the next edge (1-cycle latency). o_tc[i]=0 that cycle. Load ignores cen, dir, sat and the prescaler.
- Step condition: cen[i]=1, wen[i]=0, tick=1 (tick defined under Optional Feature).
- Up step (dir=1):
  - If o_cnt < lim, o_cnt+1.
  - If o_cnt >= lim: wrap mode sets 0; sat mode sets lim. o_tc=1 next cycle in both modes.
- Down step (dir=0):
  - If o_cnt > 0, o_cnt-1.
  - If o_cnt == 0: wrap mode sets lim; sat mode holds 0. o_tc=1.
- o_tc is a single-cycle pulse per boundary step. In saturate mode with cen held at the boundary, o_tc pulses on every step attempt.
- lim == 0: channel stays 0; every step is a boundary step (o_tc each step).
- lim lowered below the current count:
  - Up step is a boundary step: wrap sets 0, sat clamps to lim.
  - Down step decrements normally.
- lim = all-ones: full-range counter. No arithmetic overflow is possible because the boundary is detected before the increment.
- Changing dir, sat or lim takes effect on the next step; no hidden state.
- Channels are fully independent; simultaneous events on different channels never interact.
- Arithmetic is unsigned WIDTH-bit; no intermediate exceeds WIDTH bits.

Optional Feature:
- Macro: COUNTER_BANK_PRESCALE_EN.
- Defined:
  - Shared prescaler counts 0..PRESCALE-1 every clock while out of reset and wraps.
  - tick=1 only in the cycle the prescaler equals PRESCALE-1, so channels step at most once per PRESCALE clocks.
  - Prescaler runs regardless of cen/wen; reset returns it to 0.
  - PRESCALE=1 gives tick=1 always.
- Not defined: no prescaler logic; tick is constant 1; PRESCALE is ignored.

Test Plan (WIDTH=8, CHANNELS=4, macro undefined unless stated):
- rst_n=0 for 2 cycles with cen=4'hF, wen=4'hF, dat all 8'h55 -> o_cnt all 0, o_tc=0. After release with cen=0 -> values hold at 0.
- Ch0: up, wrap, lim=5, cen=1 for 8 cycles from 0 -> o_cnt 1,2,3,4,5,0,1,2. o_tc[0]=1 only in the cycle o_cnt shows 0.
- Ch1: down, sat, load dat=2, then cen=1 for 4 cycles -> 2,1,0,0,0. o_tc[1] pulses on each of the last 2 steps. Ch1 step and ch0 load in the same cycle -> both occur, neither affects the other.
- Ch2: lim=10, load dat=200 -> o_cnt=10. Then lim=3 with one up step in sat mode -> o_cnt=3, o_tc=1. Same cycle with wen=1 and cen=1 -> load wins.
- Ch3: lim=8'hFF, up, wrap, load 8'hFE, 3 steps -> FF, 00 (o_tc=1), 01. Assert rst_n=0 mid-sequence -> 0 next edge, o_tc=0.
- With COUNTER_BANK_PRESCALE_EN and PRESCALE=4: ch0 up, cen held for 12 clocks from reset -> o_cnt increments exactly 3 times, on clocks 4, 8 and 12. wen still loads within 1 cycle.

Source files
------------

// File: rtl/counter_bank.sv
// Bank of CHANNELS independent WIDTH-bit up/down counters with limit, wrap/saturate, load and terminal-count pulse.
// Optional shared step prescaler enabled by defining COUNTER_BANK_PRESCALE_EN.
module counter_bank #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int PRESCALE = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS-1:0]       cen,
  input  logic [CHANNELS-1:0]       dir,
  input  logic [CHANNELS-1:0]       sat,
  input  logic [CHANNELS-1:0]       wen,
  input  logic [CHANNELS*WIDTH-1:0] dat,
  input  logic [CHANNELS*WIDTH-1:0] lim,
  output logic [CHANNELS*WIDTH-1:0] o_cnt,
  output logic [CHANNELS-1:0]       o_tc
);

  function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] d,
                                                  input logic [WIDTH-1:0] l);
    return (d > l) ? l : d;
  endfunction

  // Returns {tc, next_count}; boundary is detected before the arithmetic so no step overflows.
  function automatic logic [WIDTH:0] step_count(input logic [WIDTH-1:0] c,
                                                input logic [WIDTH-1:0] l,
                                                input logic             up,
                                                input logic             s);
    logic [WIDTH:0] r;
    if (up) begin
      if (c >= l) r = {1'b1, (s ? l : {WIDTH{1'b0}})};
      else        r = {1'b0, c + 1'b1};
    end else begin
      if (c == '0) r = {1'b1, (s ? {WIDTH{1'b0}} : l)};
      else         r = {1'b0, c - 1'b1};
    end
    return r;
  endfunction

  logic tick;

`ifdef COUNTER_BANK_PRESCALE_EN
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pre_p0;

  always_ff @(posedge clk) begin
    if (!rst_n)                pre_p0 <= '0;
    else if (pre_p0 == PRE_LAST) pre_p0 <= '0;
    else                       pre_p0 <= pre_p0 + 1'b1;
  end

  assign tick = (pre_p0 == PRE_LAST);
`else
  assign tick = 1'b1;
`endif

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [WIDTH-1:0] cnt_p0;
    logic             tc_p0;
    logic [WIDTH-1:0] lim_i;
    logic [WIDTH-1:0] dat_i;

    assign lim_i = lim[i*WIDTH +: WIDTH];
    assign dat_i = dat[i*WIDTH +: WIDTH];

    // Stage p0: per-channel count and terminal-count registers
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        cnt_p0 <= '0;
        tc_p0  <= 1'b0;
      end else if (wen[i]) begin
        cnt_p0 <= clamp_load(dat_i, lim_i);
        tc_p0  <= 1'b0;
      end else if (cen[i] && tick) begin
        {tc_p0, cnt_p0} <= step_count(cnt_p0, lim_i, dir[i], sat[i]);
      end else begin
        tc_p0  <= 1'b0;
      end
    end

    assign o_cnt[i*WIDTH +: WIDTH] = cnt_p0;
    assign o_tc[i]                 = tc_p0;
  end

endmodule
